gpio_cmd_deserializer: RTL and testbench
========================================

Name: gpio_cmd_deserializer

Overview:
Front-end stage between the openframe GPIO pins and the timer core (user_proj_timer).
- Inputs: pins carrying a SPI-mode-0 serial command link, asynchronous to wb_clk_i.
- Function: synchronizes the pins, deserializes fixed-width command frames, buffers them in a small FIFO and hands them to the timer core over a valid/ready handshake.
- Return path: serializes a 16-bit response word back out on MISO.

Parameters:
- FRAME_W, 16: command/response frame width in bits.
- SYNC_STAGES, 2: flip-flop stages in each pin synchronizer (minimum 2).
- FIFO_DEPTH, 4: command FIFO entries; must be a power of 2.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  synchronous reset, active-high.
- spi_sck_i  input  1  serial clock from pin; asynchronous.
- spi_csn_i  input  1  chip select from pin, active-low; asynchronous.
- spi_mosi_i  input  1  serial data in from pin; asynchronous.
- spi_miso_o  output  1  serial data out.
- spi_miso_oeb_o  output  1  MISO pad output-enable, active-low.
- cmd_valid_o  output  1  FIFO head is valid.
- cmd_data_o  output  FRAME_W  FIFO head word.
- cmd_ready_i  input  1  core accepts the head word.
- rsp_data_i  input  FRAME_W  response word.
- rsp_load_i  input  1  1-cycle strobe that loads rsp_data_i.
- overflow_o  output  1  sticky: a frame was dropped because the FIFO was full.
- frame_err_o  output  1  1-cycle pulse: a bad frame was discarded.

Behaviour:
Reset values:
- cmd_valid_o=0, cmd_data_o=0, spi_miso_o=0, spi_miso_oeb_o=1, overflow_o=0, frame_err_o=0.
- FIFO empty, response register=0, bit counter=0.

Synchronization and timing:
- All three pins pass through SYNC_STAGES flops.
- sck rise/fall and csn fall/rise are detected by comparing the synced value with a 1-cycle-delayed copy.
- SCK frequency must be ≤ wb_clk_i/4; faster SCK is outside the operating range.

State machine (3 states):
- WAIT_IDLE: entered on reset. Moves to IDLE only once synced csn=1, so a frame already in progress at reset is ignored entirely.
- IDLE: on csn fall, clear the bit counter and move to SHIFT.
- SHIFT, receive: each sck rise shifts synced mosi into the LSB of the shift register (MSB-first on the wire). The bit counter increments and saturates at FRAME_W+1.
- SHIFT, transmit: on csn fall, spi_miso_o drives resp[FRAME_W-1]. Each sck fall shifts the response register left by one, filling with 0.
- SHIFT, csn rise, counter==FRAME_W: push the shift register into the FIFO. Return to IDLE.
- SHIFT, csn rise, any other count: pulse frame_err_o for 1 cycle, no push. Return to IDLE.

MISO pad enable:
- spi_miso_oeb_o = 0 only in SHIFT, else 1. Registered; it lags synced csn by 1 cycle.

FIFO:
- cmd_valid_o=1 whenever the FIFO is not empty; cmd_data_o = head word.
- A pop happens on any cycle with cmd_valid_o & cmd_ready_i.
- Latency: head word is visible on cmd_data_o with cmd_valid_o=1 on the cycle after the push, i.e. csn-rise detection + 1.
- Push while full: frame dropped, overflow_o set to 1 and held until reset.
- Push and pop in the same cycle while full: the pop frees the slot, so the push succeeds with no overflow.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.

Response register:
- rsp_load_i loads rsp_data_i only in IDLE or WAIT_IDLE.
- rsp_load_i during SHIFT is ignored, so the response cannot change mid-frame.

Optional Feature:
Macro: CMD_PARITY_EN.
- Defined: the frame is FRAME_W+1 bits long; the final bit is even parity over the FRAME_W data bits.
  - Valid frame: counter==FRAME_W+1 at csn rise and parity matches. Only the data bits are pushed.
  - Parity mismatch: frame_err_o pulse, no push.
  - Bit counter saturates at FRAME_W+2.
  - MISO sends the response's even-parity bit after the data bits.
- Undefined: plain FRAME_W-bit frames as described above; no parity logic is generated.

Test Plan:
- Reset, then a 16-bit frame 0xA5C3 at SCK=clk/8 → cmd_valid_o=1 with cmd_data_o=0xA5C3 one cycle after csn-rise detection. Hold cmd_ready_i=1 → cmd_valid_o=0 on the next cycle.
- rsp_load_i with rsp_data_i=0x1234 in IDLE, then one frame → MISO sampled on sck rises reads 0x1234; spi_miso_oeb_o=0 only during SHIFT.
- 15-bit frame, then a 17-bit frame → two frame_err_o pulses; FIFO stays empty; cmd_valid_o stays 0.
- cmd_ready_i=0, send 5 frames 0x0001..0x0005 → overflow_o=1 after frame 5. Draining pops 0x0001..0x0004 in order, then cmd_valid_o=0.
- Assert wb_rst_i after 8 bits of a frame → all outputs at reset values. The remaining 8 bits and the csn rise produce no push and no frame_err_o. The next full frame 0xBEEF is received correctly.
- CMD_PARITY_EN defined: frame 0x0003 with parity bit 0 → pushed. Frame 0x0003 with parity bit 1 → frame_err_o pulse, no push.

Source files
------------

// File: rtl/gpio_cmd_deserializer.sv
// gpio_cmd_deserializer: SPI mode-0 command front end for the timer core.
// Synchronizes the asynchronous SPI pins, deserializes fixed-width command
// frames into a small FIFO with a valid/ready output, and shifts a loadable
// response word out on MISO.
// Build option: define CMD_PARITY_EN for FRAME_W+1-bit frames whose last bit
// is even parity over the data bits (checked on receive, appended on MISO).
module gpio_cmd_deserializer #(
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               spi_sck_i,
  input  logic               spi_csn_i,
  input  logic               spi_mosi_i,
  output logic               spi_miso_o,
  output logic               spi_miso_oeb_o,
  output logic               cmd_valid_o,
  output logic [FRAME_W-1:0] cmd_data_o,
  input  logic               cmd_ready_i,
  input  logic [FRAME_W-1:0] rsp_data_i,
  input  logic               rsp_load_i,
  output logic               overflow_o,
  output logic               frame_err_o
);

`ifdef CMD_PARITY_EN
  localparam int REG_W = FRAME_W + 1;
`else
  localparam int REG_W = FRAME_W;
`endif
  localparam int CNT_MAX = REG_W + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_d, csn_d;
  logic                   sck_rise, sck_fall, csn_rise, csn_fall;

  logic [CW-1:0]          bit_cnt;
  logic [REG_W-1:0]       rx_sh;
  logic [REG_W-1:0]       resp_q;
  logic [FRAME_W-1:0]     push_word;
  logic                   frame_good;
  logic                   frame_end;
  logic                   push_req;
  logic                   bad_frame;
  logic                   oeb_q;
  logic                   err_q;
  logic                   ovf_q;

  logic [FRAME_W-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   empty, full, pop, push_ok;

  // Pin synchronizers plus one-cycle delayed copies for edge detection.
  // csn resets low so a frame already in progress never looks like a fresh
  // falling edge once reset is released.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_sync  <= '0;
      csn_sync  <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_rise = csn_s & ~csn_d;
  assign csn_fall = ~csn_s & csn_d;

`ifdef CMD_PARITY_EN
  assign frame_good = (bit_cnt == CW'(REG_W)) && (^rx_sh == 1'b0);
  assign push_word  = rx_sh[REG_W-1:1];
`else
  assign frame_good = (bit_cnt == CW'(FRAME_W));
  assign push_word  = rx_sh;
`endif

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= WAIT_IDLE;
    else          state <= state_n;
  end

  // Next-state logic and end-of-frame classification.
  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
    case (state)
      WAIT_IDLE: if (csn_s) state_n = IDLE;
      IDLE:      if (csn_fall) state_n = SHIFT;
      SHIFT: begin
        if (csn_rise) begin
          state_n   = IDLE;
          frame_end = 1'b1;
        end
      end
      default:   state_n = WAIT_IDLE;
    endcase
  end

  assign push_req  = frame_end & frame_good;
  assign bad_frame = frame_end & ~frame_good;

  // Receive shifter, saturating bit counter, response shifter and pad enable.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
      resp_q  <= '0;
      oeb_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      oeb_q <= (state_n != SHIFT);
      err_q <= bad_frame;
      if (state == IDLE && csn_fall) begin
        bit_cnt <= '0;
      end else if (state == SHIFT && sck_rise) begin
        rx_sh <= {rx_sh[REG_W-2:0], mosi_s};
        if (bit_cnt != CW'(CNT_MAX)) bit_cnt <= bit_cnt + 1'b1;
      end
      if (rsp_load_i && state != SHIFT) begin
`ifdef CMD_PARITY_EN
        resp_q <= {rsp_data_i, ^rsp_data_i};
`else
        resp_q <= rsp_data_i;
`endif
      end else if (state == SHIFT && sck_fall) begin
        resp_q <= {resp_q[REG_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso_o     = resp_q[REG_W-1];
  assign spi_miso_oeb_o = oeb_q;
  assign frame_err_o    = err_q;

  // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & cmd_ready_i;
  assign push_ok = push_req & (~full | pop);

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign cmd_valid_o = ~empty;
  assign cmd_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_gpio_cmd_deserializer.sv
// Testbench for gpio_cmd_deserializer: drives SPI frames at SCK = clk/8,
// queues expected command words and checks them in a separate monitor.
module tb_gpio_cmd_deserializer;

  localparam int FW = 16;
`ifdef CMD_PARITY_EN
  localparam int NB = FW + 1;
`else
  localparam int NB = FW;
`endif

  logic          clk, rst, sck, csn, mosi, miso, oeb;
  logic          cmd_valid, cmd_ready, rsp_load, ovf, ferr;
  logic [FW-1:0] cmd_data, rsp_data;

  int            n_total = 0;
  int            n_pass  = 0;
  int            err_cnt = 0;
  int            err0;
  logic [FW-1:0] exp_q[$];
  logic [31:0]   rx;
  logic [31:0]   raw;

  gpio_cmd_deserializer #(
    .FRAME_W    (FW),
    .SYNC_STAGES(2),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .spi_sck_i     (sck),
    .spi_csn_i     (csn),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oeb_o(oeb),
    .cmd_valid_o   (cmd_valid),
    .cmd_data_o    (cmd_data),
    .cmd_ready_i   (cmd_ready),
    .rsp_data_i    (rsp_data),
    .rsp_load_i    (rsp_load),
    .overflow_o    (ovf),
    .frame_err_o   (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] enc(logic [FW-1:0] w);
`ifdef CMD_PARITY_EN
    return {15'b0, w, ^w};
`else
    return {16'b0, w};
`endif
  endfunction

  // Shift n bits MSB-first; MISO is captured just before each SCK rise.
  task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      repeat (4) @(negedge clk);
      r = {r[30:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic start_frame();
    csn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    csn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_word(input logic [FW-1:0] w, output logic [31:0] r);
    start_frame();
    shift_bits(enc(w), NB, r);
    end_frame();
  endtask

  // Monitor: pops the scoreboard on every handshake and counts error pulses.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ferr) err_cnt++;
      if (!rst && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pop: got %h expected no word", cmd_data);
        end else begin
          check("pop_order", 32'(cmd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
    cmd_ready = 1'b0; rsp_load = 1'b0; rsp_data = '0;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_data",  32'(cmd_data),  32'd0);
    check("rst_miso",  32'(miso),      32'd0);
    check("rst_oeb",   32'(oeb),       32'd1);
    check("rst_ovf",   32'(ovf),       32'd0);
    check("rst_ferr",  32'(ferr),      32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Single frame, latency and pop with ready held high.
    cmd_ready = 1'b1;
    exp_q.push_back(16'hA5C3);
    start_frame();
    shift_bits(enc(16'hA5C3), NB, rx);
    csn = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_early_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(cmd_valid), 32'd1);
    check("lat_data",  32'(cmd_data),  32'h0000A5C3);
    @(negedge clk);
    check("lat_popped", 32'(cmd_valid), 32'd0);
    repeat (6) @(negedge clk);

    // Response readback and pad enable.
    check("oeb_idle", 32'(oeb), 32'd1);
    rsp_data = 16'h1234; rsp_load = 1'b1;
    @(negedge clk);
    rsp_load = 1'b0;
    exp_q.push_back(16'h0F0F);
    start_frame();
    check("oeb_shift", 32'(oeb), 32'd0);
    shift_bits(enc(16'h0F0F), NB, rx);
`ifdef CMD_PARITY_EN
    check("miso_1234", rx, {15'b0, 16'h1234, ^16'h1234});
`else
    check("miso_1234", rx, 32'h00001234);
`endif
    rsp_data = 16'hFFFF; rsp_load = 1'b1;
    @(negedge clk);
    rsp_load = 1'b0;
    end_frame();
    check("oeb_after", 32'(oeb), 32'd1);
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF, rx);
    check("miso_load_in_shift_ignored", rx, 32'd0);

    // Short and long frames are discarded with one error pulse each.
    err0 = err_cnt;
    start_frame();
    shift_bits(32'h00007FFF, NB - 1, rx);
    end_frame();
    start_frame();
    shift_bits(32'h0001FFFF, NB + 1, rx);
    end_frame();
    check("bad_frame_pulses", 32'(err_cnt - err0), 32'd2);
    check("bad_frame_no_push", 32'(cmd_valid), 32'd0);

    // Fill and overflow the FIFO, then drain in order.
    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(FW'(k));
      send_word(FW'(k), rx);
      if (k == 4) check("ovf_after_4", 32'(ovf), 32'd0);
    end
    check("ovf_after_5", 32'(ovf), 32'd1);
    check("full_head_valid", 32'(cmd_valid), 32'd1);
    check("full_head_data", 32'(cmd_data), 32'd1);
    cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_all", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(cmd_valid), 32'd0);

    // Reset in the middle of a frame.
    err0 = err_cnt;
    rsp_data = 16'h8001; rsp_load = 1'b1;
    @(negedge clk);
    rsp_load = 1'b0;
    start_frame();
    shift_bits(32'h000000BE, 8, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_data",  32'(cmd_data),  32'd0);
    check("mid_rst_miso",  32'(miso),      32'd0);
    check("mid_rst_oeb",   32'(oeb),       32'd1);
    check("mid_rst_ovf",   32'(ovf),       32'd0);
    check("mid_rst_ferr",  32'(ferr),      32'd0);
    rst = 1'b0;
    shift_bits(32'h000000EF, 8, rx);
    end_frame();
    check("mid_rst_no_err", 32'(err_cnt - err0), 32'd0);
    check("mid_rst_no_push", 32'(cmd_valid), 32'd0);
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, rx);

`ifdef CMD_PARITY_EN
    // Parity: correct even parity accepted, wrong parity rejected.
    err0 = err_cnt;
    exp_q.push_back(16'h0003);
    raw = {15'b0, 16'h0003, 1'b0};
    start_frame();
    shift_bits(raw, NB, rx);
    end_frame();
    raw = {15'b0, 16'h0003, 1'b1};
    start_frame();
    shift_bits(raw, NB, rx);
    end_frame();
    check("parity_err_pulse", 32'(err_cnt - err0), 32'd1);
`else
    raw = '0;
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
